// File: rtl/dff_en_write_arbiter.sv
// -----------------------------------------------------------------------------
// dff_en_write_arbiter
//
// Round-robin write arbiter and sequencer for a shared WIDTH-bit holding
// register built from DFF_EN cells. Four requesters compete for the register.
// The winner's data is driven onto reg_d with reg_en high for exactly one
// cycle, then a one-cycle ack pulse is returned to that requester.
//
// Sequence per write: IDLE (sample req) -> WRITE (reg_en=1) -> ACK (ack pulse)
// -> IDLE. Throughput is one write per three cycles. All outputs come straight
// from registers, so there is no combinational path from req to any output.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   req      [3:0]         level-sensitive write request, one bit per requester
//   data     [4*WIDTH-1:0] requester i's write data in [i*WIDTH +: WIDTH]
//   lock     [3:0]         burst-lock request (used only with ARB_LOCK_EN)
//   gnt      [3:0]         one-hot grant, zero when idle
//   ack      [3:0]         one-cycle write-complete pulse to the winner
//   reg_d    [WIDTH-1:0]   to the register's d inputs
//   reg_en                 to the register's en inputs
//   busy                   high whenever the FSM is not idle
//
// Optional feature (macro ARB_LOCK_EN):
//   When defined, a winner holding both lock and req at the end of its ACK
//   cycle goes straight back to WRITE with freshly sampled data, keeping the
//   grant and leaving the round-robin pointer untouched. Locked bursts run at
//   one write per two cycles. When undefined, lock is ignored and no lock
//   logic is built.
// -----------------------------------------------------------------------------
module dff_en_write_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data,
    input  logic [3:0]         lock,
    output logic [3:0]         gnt,
    output logic [3:0]         ack,
    output logic [WIDTH-1:0]   reg_d,
    output logic               reg_en,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;      // last-served requester
    logic [1:0]       r_winner;   // requester currently being served
    logic [3:0]       r_gnt;
    logic [3:0]       r_ack;
    logic [WIDTH-1:0] r_reg_d;
    logic             r_reg_en;
    logic             r_busy;

    logic             w_any_req;
    logic [1:0]       w_pick;
    logic [WIDTH-1:0] w_pick_data;

    // -------------------------------------------------------------------------
    // Round-robin pick: search starts at ptr+1 and wraps modulo 4. Scanning
    // from the farthest candidate down to the nearest lets the nearest
    // requesting index overwrite the others, so it wins. k = 4 wraps to ptr
    // itself, which therefore has the lowest priority.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_pick = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (req[2'(r_ptr + 2'(k))]) begin
                w_pick = 2'(r_ptr + 2'(k));
            end
        end
    end

    assign w_any_req   = |req;
    assign w_pick_data = data[int'(w_pick)*WIDTH +: WIDTH];

`ifdef ARB_LOCK_EN
    logic [WIDTH-1:0] w_winner_data;
    logic             w_lock_hold;

    // A burst continues only while the winner keeps both lock and req high.
    assign w_winner_data = data[int'(r_winner)*WIDTH +: WIDTH];
    assign w_lock_hold   = lock[r_winner] & req[r_winner];
`else
    // lock has no function in this build; fold it into a sink so it is
    // visibly consumed.
    logic w_unused_lock;
    assign w_unused_lock = ^lock;
`endif

    // -------------------------------------------------------------------------
    // Sequencer FSM. Every output is a register updated alongside the state,
    // so outputs change only on clock edges or on reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 2'd3;       // requester 0 gets first priority
            r_winner <= 2'd0;
            r_gnt    <= 4'b0000;
            r_ack    <= 4'b0000;
            r_reg_d  <= '0;
            r_reg_en <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_winner <= w_pick;
                        r_gnt    <= 4'b0001 << w_pick;
                        r_reg_d  <= w_pick_data;
                        r_reg_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    // The register captures reg_d at this edge; the ack
                    // follows in the next cycle to the granted requester.
                    r_reg_en <= 1'b0;
                    r_ack    <= r_gnt;
                    r_state  <= ST_ACK;
                end

                ST_ACK: begin
                    r_ack <= 4'b0000;
`ifdef ARB_LOCK_EN
                    if (w_lock_hold) begin
                        // Locked burst: re-sample the winner's data and write
                        // again; grant and pointer stay as they are.
                        r_reg_d  <= w_winner_data;
                        r_reg_en <= 1'b1;
                        r_state  <= ST_WRITE;
                    end else
`endif
                    begin
                        r_ptr   <= r_winner;
                        r_gnt   <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    r_gnt    <= 4'b0000;
                    r_ack    <= 4'b0000;
                    r_reg_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign ack    = r_ack;
    assign reg_d  = r_reg_d;
    assign reg_en = r_reg_en;
    assign busy   = r_busy;

endmodule

// File: tb/tb_dff_en_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_en_write_arbiter
//
// Self-checking bench for dff_en_write_arbiter (WIDTH = 8). A timeline model
// turns each arbitration decision into the list of per-cycle output views it
// must produce (one WRITE view, one ACK view) and plays them back; a compare
// process checks the DUT against the current view on every falling edge.
// Directed sequences pin the model with literal expectations, then a random
// phase exercises contention, held requests, locks and random resets.
// -----------------------------------------------------------------------------
module tb_dff_en_write_arbiter;

    localparam int W = 8;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [3:0]     req   = 4'b0000;
    logic [3:0]     lock  = 4'b0000;
    logic [4*W-1:0] data  = '0;
    logic [3:0]     gnt;
    logic [3:0]     ack;
    logic [W-1:0]   reg_d;
    logic           reg_en;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dff_en_write_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .data   (data),
        .lock   (lock),
        .gnt    (gnt),
        .ack    (ack),
        .reg_d  (reg_d),
        .reg_en (reg_en),
        .busy   (busy)
    );

    // The shared DFF_EN holding register the arbiter drives.
    logic [W-1:0] reg_q;
    always @(posedge clk or negedge reset) begin
        if (!reset)      reg_q <= '0;
        else if (reg_en) reg_q <= reg_d;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------ model
    typedef struct packed {
        logic [3:0]   gnt;
        logic [3:0]   ack;
        logic         en;
        logic         busy;
        logic [W-1:0] d;
    } view_t;

    view_t tl[$];
    view_t cur    = '0;
    int    m_last = 3;
    int    m_win  = 0;

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // One write = one WRITE-cycle view followed by one ACK-cycle view.
    task automatic push_write(input int w);
        view_t v;
        v.gnt  = 4'(1 << w);
        v.ack  = 4'b0000;
        v.en   = 1'b1;
        v.busy = 1'b1;
        v.d    = data[w*W +: W];
        tl.push_back(v);
        v.en   = 1'b0;
        v.ack  = 4'(1 << w);
        tl.push_back(v);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tl.delete();
            cur    = '0;
            m_last = 3;
        end else begin
            if (cur.ack != 4'b0000) begin
`ifdef ARB_LOCK_EN
                if (lock[m_win] && req[m_win]) push_write(m_win);
                else m_last = m_win;
`else
                m_last = m_win;
`endif
            end else if (!cur.busy && req != 4'b0000) begin
                m_win = rr_pick(req, m_last);
                push_write(m_win);
            end
            if (tl.size() > 0) begin
                cur = tl.pop_front();
            end else begin
                cur.gnt  = 4'b0000;
                cur.ack  = 4'b0000;
                cur.en   = 1'b0;
                cur.busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_gnt", gnt, 0);
            check("rst_ack", ack, 0);
            check("rst_en", reg_en, 0);
            check("rst_busy", busy, 0);
            check("rst_d", reg_d, 0);
        end else begin
            check("m_gnt", gnt, cur.gnt);
            check("m_ack", ack, cur.ack);
            check("m_en", reg_en, cur.en);
            check("m_busy", busy, cur.busy);
            if (cur.en) check("m_d", reg_d, cur.d);
        end
    end

    // --------------------------------------------------------------- helpers
    function automatic int oh_idx(input logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 9;
        endcase
    endfunction

    task automatic do_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic wait_en(input string name);
        bit ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (reg_en) ok = 1;
        end
        check(name, ok, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        int           g_idx[$];
        int           g_cyc[$];
        int           exp_order[5];
        logic [3:0]   pend;
        logic [W-1:0] burst_vals[3];

        exp_order     = '{0, 1, 2, 3, 0};
        burst_vals    = '{8'h11, 8'h22, 8'h33};

        // Reset with random requests: everything stays zero.
        req  = 4'($urandom_range(15, 1));
        data = {$urandom()};
        repeat (3) @(negedge clk);
        check("reset_outputs", {gnt, ack, reg_en, busy}, 0);

        // First write from requester 0.
        #2 reset = 1'b1;
        req = 4'b0001;
        data[0 +: W] = 8'hA5;
        @(negedge clk);
        check("first_gnt", gnt, 4'b0001);
        check("first_en", reg_en, 1);
        check("first_d", reg_d, 8'hA5);
        @(negedge clk);
        check("first_ack", ack, 4'b0001);
        check("first_en_low", reg_en, 0);
        check("first_reg_q", reg_q, 8'hA5);
        req = 4'b0000;
        @(negedge clk);
        check("first_idle", {gnt, busy}, 0);

        // Round-robin with all four requesting.
        do_reset();
        req  = 4'b1111;
        pend = 4'b0000;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (reg_en) begin
                g_idx.push_back(oh_idx(gnt));
                g_cyc.push_back(c);
            end
            if (ack != 4'b0000) begin
                pend = ack;
                req  = req & ~ack;
            end else if (pend != 4'b0000) begin
                req  = req | pend;
                pend = 4'b0000;
            end
        end
        check("rr_grants", g_idx.size() >= 5, 1);
        for (int i = 0; i < 5 && i < g_idx.size(); i++) begin
            check("rr_order", g_idx[i], exp_order[i]);
            if (i > 0) check("rr_spacing", g_cyc[i] - g_cyc[i-1], 3);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Contention after requester 1 was served: requester 2 wins.
        do_reset();
        req = 4'b0010;
        wait_en("cont_first");
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0110;
        wait_en("cont_second");
        check("cont_gnt", gnt, 4'b0100);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Mid-transaction reset: requester 3 is in WRITE when reset hits.
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        check("midrst_pre_gnt", gnt, 4'b1000);
        #2 reset = 1'b0;
        #1 check("midrst_outputs", {gnt, ack, reg_en, busy, reg_d}, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("midrst_post_gnt", gnt, 4'b0001);

        // Late request: req[3] rises during requester 0's ACK.
        req = 4'b0001;
        @(negedge clk);
        check("late_ack0", ack, 4'b0001);
        req = 4'b1000;
        begin
            int cnt  = 0;
            bit seen = 0;
            for (int k = 1; k <= 6 && !seen; k++) begin
                @(negedge clk);
                if (gnt[3]) begin
                    seen = 1;
                    cnt  = k;
                end
            end
            check("late_gnt_delay", cnt, 2);
        end
        @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);

`ifdef ARB_LOCK_EN
        // Locked burst of three writes from requester 2; requester 0 waits.
        do_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        data[2*W +: W] = 8'h11;
        begin
            int n_en    = 0;
            int n_ack2  = 0;
            int last_en = -1;
            int ack3_c  = -1;
            int gnt0_c  = -1;
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (reg_en && n_en < 3) begin
                    check("lock_gnt", gnt, 4'b0100);
                    check("lock_d", reg_d, burst_vals[n_en]);
                    if (last_en >= 0) check("lock_spacing", c - last_en, 2);
                    last_en = c;
                    n_en++;
                    if (n_en == 1) req[0] = 1'b1;
                    if (n_en < 3) data[2*W +: W] = burst_vals[n_en];
                end
                if (ack[2]) begin
                    n_ack2++;
                    check("lock_reg_q", reg_q, burst_vals[n_ack2-1]);
                    if (n_ack2 == 3) begin
                        ack3_c  = c;
                        lock[2] = 1'b0;
                        req[2]  = 1'b0;
                    end
                end
                if (gnt[0] && gnt0_c < 0) gnt0_c = c;
                if (ack[0]) req[0] = 1'b0;
            end
            check("lock_ack_count", n_ack2, 3);
            check("lock_req0_after", gnt0_c > ack3_c && ack3_c >= 0, 1);
        end
        req  = 4'b0000;
        lock = 4'b0000;
        repeat (3) @(negedge clk);
`endif

        // Random phase: the timeline model checks every cycle.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                end
                lock[i] = 1'($urandom_range(1, 0));
                data[i*W +: W] = W'($urandom());
            end
            if ($urandom_range(149, 0) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
        end

        req  = 4'b0000;
        lock = 4'b0000;
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dff_en_write_arbiter.md
# dff_en_write_arbiter

Round-robin write arbiter and sequencer for a WIDTH-bit holding register built from `DFF_EN` cells. Four requesters share the register. The block picks one requester, drives the register's `d` and `en` inputs for exactly one write cycle, and returns a one-cycle acknowledge. It sits between the requesters and the register bank and is the only driver of the register's `d` and `en` pins.

## Interface
- `WIDTH`, default 8: data width of each requester and of the shared register.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `req` input, 4 bits: write request, one bit per requester, level-sensitive.
- `data` input, 4*WIDTH bits: requester i's write data in bits `[i*WIDTH +: WIDTH]`.
- `lock` input, 4 bits: burst-lock request per requester. Used only when `ARB_LOCK_EN` is defined.
- `gnt` output, 4 bits: one-hot grant; all zeros when idle.
- `ack` output, 4 bits: one-cycle write-complete pulse to the granted requester.
- `reg_d` output, WIDTH bits: connects to the register's `d` inputs.
- `reg_en` output, 1 bit: connects to the register's `en` inputs.
- `busy` output, 1 bit: high whenever state is not IDLE.

## Operation
- Registered FSM with three states: IDLE, WRITE, ACK.
- Pointer `ptr` (2 bits) holds the last-served requester index.
- IDLE:
  - At each edge, if any `req` bit is high, select the winner. The search starts at `ptr+1` and wraps modulo 4.
  - On selection: register `gnt` as one-hot of the winner, register `reg_d = data[winner]`, go to WRITE.
  - If no request, stay in IDLE.
- WRITE:
  - `reg_en = 1`; `reg_d` holds the latched value.
  - Next state is ACK unconditionally.
- ACK:
  - `reg_en = 0`; `ack[winner] = 1`; `gnt` held.
  - Set `ptr = winner`.
  - Next state is IDLE, and `gnt` clears.
- Outputs are Moore outputs decoded from state or taken from registers. There are no combinational paths from `req` to any output.
- Requester obligations:
  - `data` must be valid at the edge where `req` is sampled. It is not sampled again.
  - `req` must be low by the first IDLE cycle after its `ack`. A `req` still high there is treated as a new request, subject to round-robin.
- Requests arriving during WRITE or ACK are ignored until the block returns to IDLE. They are not lost as long as they are held.
- Simultaneous requests: exactly one grant per arbitration; no requester is starved.
- Reset values (asynchronous, while `reset` is low, including mid-transaction):
  - state IDLE, `ptr` = 3, so requester 0 has first priority.
  - `gnt` = 0, `ack` = 0, `reg_en` = 0, `reg_d` = 0, `busy` = 0.
- An interrupted write is not acked and not retried. The requester must re-request.

## Timing
- Edge E0: IDLE samples `req`.
- Cycle after E0: `reg_en` = 1, `gnt` and `reg_d` valid.
- Edge E1: the register captures `reg_d`.
- Cycle after E1: `ack` high for exactly one cycle.
- Edge E2: `gnt` clears and the FSM is back in IDLE.
- Next arbitration happens at E3. Throughput is one write per 3 cycles.
- `reg_en` is never high for more than one consecutive cycle, except under a lock (see Configuration).
- `busy` is high for cycles E0+ through E2-.

## Configuration
- Macro: `ARB_LOCK_EN`.
- Defined:
  - In ACK, if `lock[winner]` and `req[winner]` are both high, the next state is WRITE instead of IDLE.
  - `reg_d` re-registers `data[winner]` at that edge, `gnt` is held and `ptr` is not updated.
  - Locked bursts run at one write per 2 cycles, with no length limit.
  - `ptr` updates only on the final, unlocked ACK.
- Not defined: `lock` is ignored, the behaviour is exactly as above, and no lock logic is synthesized.

## Test plan
- Reset: hold `reset` low with random `req`. All outputs are 0. Release, then `req=4'b0001`, `data[0]=8'hA5`:
  - `gnt=0001` and `reg_en=1` one cycle after the sample edge.
  - `reg_d=8'hA5`.
  - `ack[0]` pulses on the next cycle; the register reads A5.
- Round-robin: `req=4'b1111` held, with `req[i]` dropped after each `ack[i]` and re-raised. Grant order is 0,1,2,3,0,…, with one write every 3 cycles.
- Contention after service: requesters 1 and 2 held high after requester 1 was last served. Requester 2 is granted first.
- Mid-transaction reset: assert `reset` low during WRITE.
  - Outputs go to 0 immediately, with no `ack`.
  - After release, requester 0 wins even if 3 also requests.
- Late request: `req[3]` rises during ACK of requester 0. It is granted at the next IDLE sample; `gnt[3]` is asserted 2 cycles after the ack.
- With `ARB_LOCK_EN`: requester 2 holds `lock[2]` and `req[2]` for writes 11, 22, 33.
  - `reg_en` pulses every 2 cycles, `gnt` is constant at 0100 and `ack[2]` pulses 3 times.
  - Requester 0's pending request waits until `lock` drops.
